// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - 16-bit rotate/shift unit processing one Cnt bit per cycle over four stages
module iterative_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [15:0] work;
  logic [15:0] work_next;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [1:0]  stage;
  logic [4:0]  amt;
  logic [15:0] stepped;

  // Stage k moves the word by 2^k; the fixed stage count keeps latency independent of Cnt.
  assign amt = 5'd1 << stage;

  always_comb begin
    stepped = work;
    case (op_q)
      OP_ROL: stepped = (work << amt) | (work >> (5'd16 - amt));
      OP_SLL: stepped = work << amt;
      OP_ROR: stepped = (work >> amt) | (work << (5'd16 - amt));
      OP_SRA: stepped = $unsigned($signed(work) >>> amt);
      default: stepped = work;
    endcase
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = SHIFT;
          work_next  = In;
        end
      end
      SHIFT: begin
        if (cnt_q[stage]) work_next = stepped;
        if (stage == 2'd3) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= 16'h0000;
      cnt_q <= 4'd0;
      op_q  <= 2'd0;
      stage <= 2'd0;
    end else begin
      state <= state_next;
      work  <= work_next;
      if (state == IDLE && in_valid) begin
        cnt_q <= Cnt;
        op_q  <= Op;
        stage <= 2'd0;
      end else if (state == SHIFT) begin
        stage <= stage + 2'd1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign Out       = work;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - directed-vector bench for iterative_shifter
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] In = 16'h0000;
  logic [3:0]  Cnt = 4'd0;
  logic [1:0]  Op = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  iterative_shifter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .In(In), .Cnt(Cnt), .Op(Op), .out_valid(out_valid),
    .out_ready(out_ready), .Out(Out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one request and wait for the result, scrambling inputs in flight.
  task automatic start_op(input logic [1:0] op, input logic [15:0] din, input logic [3:0] cnt,
                          output int latency);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    Op = op; In = din; Cnt = cnt; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    In = ~din; Cnt = ~cnt; Op = ~op;
    latency = 0;
    while (!out_valid && latency < 10) begin
      tick();
      latency++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] din,
                        input logic [3:0] cnt, input logic [15:0] exp);
    int lat;
    start_op(op, din, cnt, lat);
    check_eq({tag, "_latency"}, lat, 32'd4);
    check_eq({tag, "_out"}, {16'd0, Out}, {16'd0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10] = '{
    '{2'b00, 16'h8001, 4'd1,  16'h0003},
    '{2'b01, 16'h00FF, 4'd4,  16'h0FF0},
    '{2'b10, 16'h0001, 4'd2,  16'h4000},
    '{2'b11, 16'h8000, 4'd15, 16'hFFFF},
    '{2'b11, 16'h4000, 4'd3,  16'h0800},
    '{2'b11, 16'h1234, 4'd0,  16'h1234},
    '{2'b00, 16'h1234, 4'd4,  16'h2341},
    '{2'b01, 16'hFFFF, 4'd15, 16'h8000},
    '{2'b10, 16'h1234, 4'd8,  16'h3412},
    '{2'b11, 16'h8421, 4'd4,  16'hF842}
  };

  initial begin
    int lat;
    #2;
    check_eq("reset_out", {16'd0, Out}, 32'd0);
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].cnt, vecs[i].exp);

    // Backpressure: result must hold while out_ready is low and new requests are ignored.
    start_op(2'b00, 16'hABCD, 4'd4, lat);
    check_eq("bp_latency", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; In = 16'h5555; Cnt = 4'd1; Op = 2'b01;
      tick();
      in_valid = 1'b0;
      check_eq($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("bp_out%0d", i), {16'd0, Out}, 32'h0000BCDA);
      check_eq($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_no_accept_on_handshake", {31'd0, busy}, 32'd0);
    check_eq("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    check_eq("bp_still_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of SHIFT aborts the operation.
    Op = 2'b00; In = 16'hF00F; Cnt = 4'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out", {16'd0, Out}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_no_result", {31'd0, out_valid}, 32'd0);
    run_op("post_rst", 2'b00, 16'hF00F, 4'd6, 16'h03FC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits and the count width at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  request present on In/Cnt/Op.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 In  input  16  operand.
REQ-007 Cnt  input  4  shift amount, 0-15.
REQ-008 Op  input  2  operation: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right arithmetic.
REQ-009 out_valid  output  1  result present on Out.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 Out  output  16  result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where the FSM is in IDLE and in_valid=1.
REQ-016 On acceptance, the block SHALL latch In into a 16-bit working register, latch Cnt and Op, set the stage index to 0, and enter SHIFT.
REQ-017 In SHIFT, each edge SHALL process the current stage k (k=0..3) and then increment k.
REQ-018 At stage k, if the latched Cnt[k]=1, the working register SHALL be shifted by 2^k per Op; if Cnt[k]=0, it SHALL hold its value.
REQ-019 Rotates SHALL wrap the bits shifted out back in at the opposite end.
REQ-020 Shift left logical SHALL fill vacated bits with 0.
REQ-021 Shift right arithmetic SHALL fill vacated bits with bit 15 of the working register at that stage.
REQ-022 On the stage-3 edge, the FSM SHALL enter DONE; out_valid SHALL rise exactly 4 edges after the accept edge, independent of Cnt.
REQ-023 Cnt=0 SHALL still take 4 cycles and SHALL return Out=In.
REQ-024 In DONE, out_valid SHALL be 1 and Out SHALL equal the working register, held stable until the handshake.
REQ-025 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE; out_valid SHALL be 0 in all other states.
REQ-026 No new request SHALL be accepted in the same edge as the output handshake; the minimum issue interval is 6 cycles.
REQ-027 In/Cnt/Op and in_valid SHALL be ignored outside IDLE; changes to them SHALL NOT affect an operation in flight.
REQ-028 Out SHALL reflect the working register in all states, and SHALL be meaningful only while out_valid=1.

Reset
REQ-029 While rst=1, the block SHALL immediately force: state IDLE, stage index 0, working register 0x0000, latched Cnt/Op 0.
REQ-030 As a consequence, under reset out_valid=0, busy=0, Out=0x0000 and in_ready=1.
REQ-031 Reset asserted during SHIFT or DONE SHALL abort the operation with no result produced; the first accept after deassertion SHALL behave normally.

Verification
REQ-032 Rotate left: Op=00, In=0x8001, Cnt=1 -> out_valid 4 edges after accept, Out=0x0003.
REQ-033 Shift left logical and rotate right: Op=01, In=0x00FF, Cnt=4 -> Out=0x0FF0; Op=10, In=0x0001, Cnt=2 -> Out=0x4000.
REQ-034 Arithmetic right: Op=11, In=0x8000, Cnt=15 -> Out=0xFFFF; Op=11, In=0x4000, Cnt=3 -> Out=0x0800; Op=11, In=0x1234, Cnt=0 -> Out=0x1234 after 4 cycles.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in DONE -> Out and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 Reset mid-operation: assert rst at stage 2 of Op=00, In=0xF00F, Cnt=6 -> Out=0x0000 and busy=0 immediately; a subsequent request completes correctly.
